vram_write_port: RTL and testbench
==================================

Name: vram_write_port

Overview:
- CPU-side writer for the four PPU video memories: sprite, map, tile and palette RAM.
- Accepts 32-bit word writes over a valid/ready request port and buffers them in a small FIFO.
- Routes each word to the target RAM by address region and width-converts it to that RAM's data width (map 16-bit, tile 8-bit).
- Optionally holds commits until the display is in blanking, so the PPU's scanline fetch never sees a mid-frame update.

Parameters:
- FIFO_DEPTH, 4, request buffer depth in entries; power of two, at least 2.
- BLANK_ONLY, 1, when 1 a RAM write strobe may only assert while blank=1; when 0 blank is ignored.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- blank  input  1  high during hblank or vblank, from the display timing generator.
- req_valid  input  1  write request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_addr  input  15  bits [14:13] select the region (0 sprite, 1 map, 2 tile, 3 palette); bits [12:0] are the word index.
- req_data  input  32  write data, little-endian lanes.
- req_be  input  4  byte-lane enables.
- sp_we, sp_addr, sp_wdata  output  1, SP_ADDR_W, SP_DATA_W  sprite RAM write port.
- map_we, map_addr, map_wdata  output  1, MAP_ADDR_W, MAP_DATA_W  map RAM write port.
- tile_we, tile_addr, tile_wdata  output  1, TILE_ADDR_W, TILE_DATA_W  tile RAM write port.
- pal_we, pal_addr, pal_wdata  output  1, PAL_ADDR_W, PAL_DATA_W  palette RAM write port.
- busy  output  1  FIFO non-empty or engine not IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - all *_we=0, all addr/wdata=0, busy=0, req_ready=1 from the cycle after rst is sampled.
  - FIFO is emptied and the engine returns to IDLE.
  - Reset mid-word discards the remaining lanes; no further strobes are issued.
- FIFO:
  - req_ready = !full.
  - A push while full cannot happen, because ready is low.
  - Push and pop in the same cycle are allowed at any occupancy except a push when full.
  - No bypass: a word accepted in cycle N is visible at the FIFO head in N+1.
- Engine states IDLE, LOAD, EMIT:
  - IDLE: when the FIFO is non-empty, pop the head and go to LOAD.
  - LOAD: latch region, index, data and be; set lane=0 and count (sprite/palette 1, map 2, tile 4); go to EMIT.
  - EMIT: each cycle with (blank || !BLANK_ONLY), issue one lane and increment lane. When lane==count-1 has issued, go to IDLE.
  - EMIT with blank=0 and BLANK_ONLY=1: stall and hold the lane; no strobe. A word may straddle blank periods.
- Outputs are registered. Minimum latency from request acceptance at cycle N to the first we is cycle N+3. Steady-state throughput is one lane per cycle plus 2 overhead cycles per word.
- Sprite and palette regions:
  - one write of the full 32 bits.
  - sp_addr=index[9:0]; pal_addr=index[7:0].
  - Issued only if be!=0. be==0 consumes the EMIT cycle with no strobe.
- Map region:
  - lane h in {0,1}: map_addr={index[9:0],h}, map_wdata=data[16h+15:16h].
  - Strobe only if be[2h+1:2h]!=0.
- Tile region:
  - lane b in 0..3: tile_addr={index[12:0],b}, tile_wdata=data[8b+7:8b].
  - Strobe only if be[b]=1.
- Disabled lanes still take their cycle, so timing depends only on region and blank.
- Index bits above a region's address width are ignored; no error is flagged.
- At most one *_we is high in any cycle. Addr and wdata hold their last value when we=0.
- busy=0 only when the FIFO is empty and the engine is in IDLE.

Decomposition:
- Shared package:
  - region encoding enum: REG_SP=0, REG_MAP=1, REG_TILE=2, REG_PAL=3.
  - the existing address/data width constants.
  - packed request struct {region, index, data, be}.
- Sub-module: vram_req_fifo, a synchronous single-clock FIFO of the request struct with full/empty flags; it is also reused by other bus bridges.

Test Plan:
- Sprite word at blank=1:
  - stimulus: addr={2'd0,13'd5}, data=32'hDEADBEEF, be=4'hF.
  - required: exactly one sp_we pulse at N+3, sp_addr=5, sp_wdata=32'hDEADBEEF; busy falls the cycle after.
- Tile word at blank=1:
  - stimulus: addr={2'd2,13'd3}, data=32'h44332211, be=4'b1011.
  - required: tile_we pulses at lanes 0, 1, 3 (addrs 12, 13, 15; data 11, 22, 44); lane 2 cycle has no strobe.
- Map word with BLANK_ONLY=1:
  - stimulus: addr={2'd1,13'd7}, data=32'hBBBBAAAA, be=4'hF; blank=0 for 10 cycles, 1 for 1 cycle, 0 for 5 cycles, then 1.
  - required: map write (14, AAAA) in the first blank cycle; (15, BBBB) in the second blank period; no strobe while blank=0.
- FIFO back-pressure:
  - stimulus: blank=0, push 6 words back-to-back.
  - required: req_ready drops after 4 accepts (plus 1 held in the engine); raising blank drains all words in order.
- Reset mid-tile-word:
  - stimulus: assert rst after lane 1.
  - required: no further tile_we; next cycle req_ready=1, busy=0; a new palette write then lands correctly.
- Palette with be=0:
  - stimulus: palette word with be=0.
  - required: no pal_we; busy returns to 0 after 3 cycles.

Source files
------------

// File: rtl/vram_write_port_pkg.sv
// Shared types and geometry for the PPU video-memory write path.
// Region encoding, RAM widths and the buffered request record.
package vram_write_port_pkg;

  localparam int SP_ADDR_W   = 10;
  localparam int SP_DATA_W   = 32;
  localparam int MAP_ADDR_W  = 11;
  localparam int MAP_DATA_W  = 16;
  localparam int TILE_ADDR_W = 15;
  localparam int TILE_DATA_W = 8;
  localparam int PAL_ADDR_W  = 8;
  localparam int PAL_DATA_W  = 32;

  localparam int INDEX_W = 13;
  localparam int WORD_W  = 32;
  localparam int BE_W    = 4;

  typedef enum logic [1:0] {
    REG_SP   = 2'd0,
    REG_MAP  = 2'd1,
    REG_TILE = 2'd2,
    REG_PAL  = 2'd3
  } region_t;

  typedef struct packed {
    region_t              region;
    logic [INDEX_W-1:0]   index;
    logic [WORD_W-1:0]    data;
    logic [BE_W-1:0]      be;
  } req_t;

  // Number of RAM writes a 32-bit word expands into for a region.
  function automatic logic [2:0] region_lanes(input region_t region);
    case (region)
      REG_MAP:  region_lanes = 3'd2;
      REG_TILE: region_lanes = 3'd4;
      default:  region_lanes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/vram_req_fifo.sv
// Synchronous single-clock FIFO of write requests with full/empty flags.
// No bypass: a pushed entry reaches the head on the following cycle.
module vram_req_fifo
  import vram_write_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  req_t                   wdata,
  input  logic                   pop,
  output req_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  req_t             mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/vram_write_port.sv
// CPU-side writer for sprite, map, tile and palette RAM: buffers 32-bit
// words, splits them into RAM-width lanes and optionally commits only in blanking.
module vram_write_port
  import vram_write_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blank,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [14:0]            req_addr,
  input  logic [31:0]            req_data,
  input  logic [3:0]             req_be,
  output logic                   sp_we,
  output logic [SP_ADDR_W-1:0]   sp_addr,
  output logic [SP_DATA_W-1:0]   sp_wdata,
  output logic                   map_we,
  output logic [MAP_ADDR_W-1:0]  map_addr,
  output logic [MAP_DATA_W-1:0]  map_wdata,
  output logic                   tile_we,
  output logic [TILE_ADDR_W-1:0] tile_addr,
  output logic [TILE_DATA_W-1:0] tile_wdata,
  output logic                   pal_we,
  output logic [PAL_ADDR_W-1:0]  pal_addr,
  output logic [PAL_DATA_W-1:0]  pal_wdata,
  output logic                   busy
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t             state_r, state_n;
  req_t               cur_r, cur_n;
  logic [1:0]         lane_r, lane_n;
  logic [2:0]         count_r, count_n;
  req_t               in_req, head;
  logic               full, empty, pop, push_acc, go, map_en;
  logic [LVL_W-1:0]   level;

  logic                   sp_we_n, map_we_n, tile_we_n, pal_we_n, busy_n;
  logic [SP_ADDR_W-1:0]   sp_addr_n;
  logic [SP_DATA_W-1:0]   sp_wdata_n;
  logic [MAP_ADDR_W-1:0]  map_addr_n;
  logic [MAP_DATA_W-1:0]  map_wdata_n;
  logic [TILE_ADDR_W-1:0] tile_addr_n;
  logic [TILE_DATA_W-1:0] tile_wdata_n;
  logic [PAL_ADDR_W-1:0]  pal_addr_n;
  logic [PAL_DATA_W-1:0]  pal_wdata_n;

  assign in_req    = '{region: region_t'(req_addr[14:13]), index: req_addr[12:0],
                       data: req_data, be: req_be};
  assign req_ready = !full;
  assign push_acc  = req_valid && !full;
  assign go        = blank || !BLANK_ONLY;
  assign map_en    = lane_r[0] ? (|cur_r.be[3:2]) : (|cur_r.be[1:0]);

  vram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .wdata (in_req),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // The word is captured on the popping edge, since the head moves on after it.
  always_comb begin
    state_n      = state_r;
    cur_n        = cur_r;
    lane_n       = lane_r;
    count_n      = count_r;
    pop          = 1'b0;
    sp_we_n      = 1'b0;
    map_we_n     = 1'b0;
    tile_we_n    = 1'b0;
    pal_we_n     = 1'b0;
    sp_addr_n    = sp_addr;
    sp_wdata_n   = sp_wdata;
    map_addr_n   = map_addr;
    map_wdata_n  = map_wdata;
    tile_addr_n  = tile_addr;
    tile_wdata_n = tile_wdata;
    pal_addr_n   = pal_addr;
    pal_wdata_n  = pal_wdata;
    case (state_r)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_n   = head;
          state_n = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        lane_n  = 2'd0;
        count_n = region_lanes(cur_r.region);
        state_n = EMIT;
      end
      EMIT: begin
        if (go) begin
          case (cur_r.region)
            REG_SP: begin
              if (|cur_r.be) begin
                sp_we_n    = 1'b1;
                sp_addr_n  = cur_r.index[SP_ADDR_W-1:0];
                sp_wdata_n = cur_r.data;
              end else begin
                sp_we_n = 1'b0;
              end
            end
            REG_MAP: begin
              if (map_en) begin
                map_we_n    = 1'b1;
                map_addr_n  = {cur_r.index[MAP_ADDR_W-2:0], lane_r[0]};
                map_wdata_n = lane_r[0] ? cur_r.data[31:16] : cur_r.data[15:0];
              end else begin
                map_we_n = 1'b0;
              end
            end
            REG_TILE: begin
              if (cur_r.be[lane_r]) begin
                tile_we_n    = 1'b1;
                tile_addr_n  = {cur_r.index, lane_r};
                tile_wdata_n = cur_r.data[{lane_r, 3'b000} +: 8];
              end else begin
                tile_we_n = 1'b0;
              end
            end
            REG_PAL: begin
              if (|cur_r.be) begin
                pal_we_n    = 1'b1;
                pal_addr_n  = cur_r.index[PAL_ADDR_W-1:0];
                pal_wdata_n = cur_r.data;
              end else begin
                pal_we_n = 1'b0;
              end
            end
            default: begin
              sp_we_n = 1'b0;
            end
          endcase
          if ({1'b0, lane_r} == (count_r - 3'd1)) begin
            state_n = IDLE;
          end else begin
            lane_n = lane_r + 2'd1;
          end
        end else begin
          state_n = EMIT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Busy covers the strobe being presented as well as queued and in-flight work.
    busy_n = push_acc || (level > LVL_W'(pop)) || (state_n != IDLE) ||
             sp_we_n || map_we_n || tile_we_n || pal_we_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cur_r      <= '0;
      lane_r     <= 2'd0;
      count_r    <= 3'd0;
      sp_we      <= 1'b0;
      map_we     <= 1'b0;
      tile_we    <= 1'b0;
      pal_we     <= 1'b0;
      sp_addr    <= '0;
      sp_wdata   <= '0;
      map_addr   <= '0;
      map_wdata  <= '0;
      tile_addr  <= '0;
      tile_wdata <= '0;
      pal_addr   <= '0;
      pal_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_n;
      cur_r      <= cur_n;
      lane_r     <= lane_n;
      count_r    <= count_n;
      sp_we      <= sp_we_n;
      map_we     <= map_we_n;
      tile_we    <= tile_we_n;
      pal_we     <= pal_we_n;
      sp_addr    <= sp_addr_n;
      sp_wdata   <= sp_wdata_n;
      map_addr   <= map_addr_n;
      map_wdata  <= map_wdata_n;
      tile_addr  <= tile_addr_n;
      tile_wdata <= tile_wdata_n;
      pal_addr   <= pal_addr_n;
      pal_wdata  <= pal_wdata_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_vram_write_port.sv
// Self-checking bench for vram_write_port: directed scenarios plus random
// traffic scored against a word-to-RAM-write expansion model.
module tb_vram_write_port;
  import vram_write_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst, blank, req_valid, req_ready;
  logic [14:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        sp_we, map_we, tile_we, pal_we, busy;
  logic [SP_ADDR_W-1:0]   sp_addr;
  logic [SP_DATA_W-1:0]   sp_wdata;
  logic [MAP_ADDR_W-1:0]  map_addr;
  logic [MAP_DATA_W-1:0]  map_wdata;
  logic [TILE_ADDR_W-1:0] tile_addr;
  logic [TILE_DATA_W-1:0] tile_wdata;
  logic [PAL_ADDR_W-1:0]  pal_addr;
  logic [PAL_DATA_W-1:0]  pal_wdata;

  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
    int          edge_n;
    bit          blank_ok;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  cyc = 0;
  bit  blank_at_edge = 1'b0;
  int  multi_we = 0;
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  vram_write_port #(.FIFO_DEPTH(4), .BLANK_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst), .blank(blank),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .sp_we(sp_we), .sp_addr(sp_addr), .sp_wdata(sp_wdata),
    .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .tile_we(tile_we), .tile_addr(tile_addr), .tile_wdata(tile_wdata),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .busy(busy)
  );

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    blank_at_edge <= blank;
  end

  // Observed RAM writes, stamped with the clock edge that produced them.
  initial begin
    forever begin
      @(negedge clk);
      if ((int'(sp_we) + int'(map_we) + int'(tile_we) + int'(pal_we)) > 1) multi_we++;
      if (sp_we)   obs_q.push_back('{0, int'(sp_addr), sp_wdata, cyc - 1, blank_at_edge});
      if (map_we)  obs_q.push_back('{1, int'(map_addr), 32'(map_wdata), cyc - 1, blank_at_edge});
      if (tile_we) obs_q.push_back('{2, int'(tile_addr), 32'(tile_wdata), cyc - 1, blank_at_edge});
      if (pal_we)  obs_q.push_back('{3, int'(pal_addr), pal_wdata, cyc - 1, blank_at_edge});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the RAM writes one accepted word must produce, in order.
  task automatic expect_word(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    idx = int'(a[12:0]);
    case (a[14:13])
      2'd0: if (be != 4'h0) exp_q.push_back('{0, idx % 1024, d, 0, 1'b1});
      2'd1: for (int h = 0; h < 2; h++)
              if (((be >> (2 * h)) & 4'h3) != 4'h0)
                exp_q.push_back('{1, (idx % 1024) * 2 + h, (d >> (16 * h)) & 32'hFFFF, 0, 1'b1});
      2'd2: for (int b = 0; b < 4; b++)
              if (be[b]) exp_q.push_back('{2, idx * 4 + b, (d >> (8 * b)) & 32'hFF, 0, 1'b1});
      default: if (be != 4'h0) exp_q.push_back('{3, idx % 256, d, 0, 1'b1});
    endcase
  endtask

  // Called at a falling edge; returns the accepting edge index or -1 on timeout.
  task automatic push(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be,
                      input int max_wait, output int acc_edge);
    int waited;
    waited = 0;
    req_valid = 1'b1; req_addr = a; req_data = d; req_be = be;
    while (!req_ready && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready) begin
      @(posedge clk);
      acc_edge = cyc;
      expect_word(a, d, be);
      @(negedge clk);
    end else begin
      acc_edge = -1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; blank = 1'b0; req_valid = 1'b0;
    req_addr = 15'd0; req_data = 32'd0; req_be = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++;
    if ({sp_we, map_we, tile_we, pal_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_we got %b want 0000", {sp_we, map_we, tile_we, pal_we});
    end
    checks++;
    if ({sp_addr, map_addr, tile_addr, pal_addr} !== '0 ||
        {sp_wdata, map_wdata, tile_wdata, pal_wdata} !== '0) begin
      errors++; $display("FAIL reset_addr_data got nonzero addr/wdata want 0");
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sprite();
    int acc;
    bit ok;
    blank = 1'b1;
    push({2'd0, 13'd5}, 32'hDEADBEEF, 4'hF, 5, acc);
    repeat (3) @(negedge clk);
    checks++;
    if (sp_we !== 1'b1 || sp_addr !== 10'd5 || sp_wdata !== 32'hDEADBEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL sprite_strobe got we=%b addr=%0d data=%h busy=%b want 1 5 deadbeef 1",
               sp_we, sp_addr, sp_wdata, busy);
    end
    @(negedge clk);
    checks++;
    if (sp_we !== 1'b0 || busy !== 1'b0 || sp_addr !== 10'd5) begin
      errors++; $display("FAIL sprite_after got we=%b busy=%b addr=%0d want 0 0 5", sp_we, busy, sp_addr);
    end
    wait_idle(20, ok);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].edge_n != acc + 3) begin
      errors++; $display("FAIL sprite_count got %0d writes want 1 at edge %0d", obs_q.size(), acc + 3);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_tile();
    int acc;
    bit ok;
    int want_edge[3];
    blank = 1'b1;
    push({2'd2, 13'd3}, 32'h44332211, 4'b1011, 5, acc);
    want_edge[0] = acc + 3; want_edge[1] = acc + 4; want_edge[2] = acc + 6;
    wait_idle(30, ok);
    checks++;
    if (!ok || obs_q.size() != 3 || exp_q.size() != 3) begin
      errors++; $display("FAIL tile_count got %0d writes want 3 (idle=%0d)", obs_q.size(), ok);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size() && i < 3; i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].addr != exp_q[i].addr ||
          obs_q[i].data !== exp_q[i].data || obs_q[i].edge_n != want_edge[i]) begin
        errors++;
        $display("FAIL tile_lane[%0d] got k%0d a%0d d%h e%0d want k%0d a%0d d%h e%0d", i,
                 obs_q[i].kind, obs_q[i].addr, obs_q[i].data, obs_q[i].edge_n,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data, want_edge[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_map_blank();
    int acc, e1, e2;
    bit ok;
    blank = 1'b0;
    push({2'd1, 13'd7}, 32'hBBBBAAAA, 4'hF, 5, acc);
    repeat (9) @(negedge clk);
    blank = 1'b1; e1 = cyc;
    @(negedge clk);
    blank = 1'b0;
    repeat (5) @(negedge clk);
    blank = 1'b1; e2 = cyc;
    wait_idle(30, ok);
    checks++;
    if (!ok || obs_q.size() != 2 || exp_q.size() != 2) begin
      errors++; $display("FAIL map_count got %0d writes want 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size() && i < 2; i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].addr != exp_q[i].addr ||
          obs_q[i].data !== exp_q[i].data || !obs_q[i].blank_ok ||
          obs_q[i].edge_n != ((i == 0) ? e1 : e2)) begin
        errors++;
        $display("FAIL map_lane[%0d] got a%0d d%h e%0d blank%0d want a%0d d%h e%0d", i,
                 obs_q[i].addr, obs_q[i].data, obs_q[i].edge_n, obs_q[i].blank_ok,
                 exp_q[i].addr, exp_q[i].data, (i == 0) ? e1 : e2);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int acc, n_acc;
    bit ok;
    logic [14:0] a[6];
    logic [31:0] d[6];
    logic [3:0]  be[6];
    for (int i = 0; i < 6; i++) begin
      a[i] = 15'($urandom); d[i] = $urandom; be[i] = 4'($urandom_range(1, 15));
    end
    blank = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push(a[i], d[i], be[i], 2, acc);
      if (acc >= 0) n_acc++;
    end
    req_valid = 1'b1; req_addr = a[5]; req_data = d[5]; req_be = be[5];
    repeat (6) @(negedge clk);
    checks++;
    if (n_acc != 5 || req_ready !== 1'b0) begin
      errors++; $display("FAIL backpressure got accepts=%0d ready=%b want 5 0", n_acc, req_ready);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL backpressure_hold got %0d writes outside blank want 0", obs_q.size());
    end
    blank = 1'b1;
    push(a[5], d[5], be[5], 40, acc);
    checks++;
    if (acc < 0) begin errors++; $display("FAIL backpressure_sixth got timeout want accept"); end
    wait_idle(200, ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL drain_count got %0d writes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].addr != exp_q[i].addr ||
          obs_q[i].data !== exp_q[i].data || !obs_q[i].blank_ok) begin
        errors++;
        $display("FAIL drain[%0d] got k%0d a%0d d%h want k%0d a%0d d%h", i,
                 obs_q[i].kind, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_tile();
    int acc;
    bit ok;
    logic [14:0] pa;
    logic [31:0] pd;
    blank = 1'b1;
    push({2'd2, 13'($urandom)}, $urandom, 4'hF, 5, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tile_we !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset got we=%b ready=%b busy=%b want 0 1 0", tile_we, req_ready, busy);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 2 || obs_q[0].addr != exp_q[0].addr || obs_q[1].addr != exp_q[1].addr ||
        obs_q[1].data !== exp_q[1].data) begin
      errors++; $display("FAIL midreset_lanes got %0d writes want 2 (lanes 0,1)", obs_q.size());
    end
    obs_q.delete(); exp_q.delete();
    pa = {2'd3, 13'($urandom)}; pd = $urandom;
    push(pa, pd, 4'($urandom_range(1, 15)), 5, acc);
    wait_idle(30, ok);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0].kind != 3 ||
        obs_q[0].addr != exp_q[0].addr || obs_q[0].data !== exp_q[0].data) begin
      errors++; $display("FAIL midreset_pal got %0d writes want 1 to addr %0d data %h",
                         obs_q.size(), pa[7:0], pd);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pal_be0();
    int acc;
    blank = 1'b1;
    push({2'd3, 13'd9}, 32'h12345678, 4'h0, 5, acc);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL be0_busy_hold got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL be0_busy_fall got %b want 0", busy); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL be0_nowrite got %0d writes want 0", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int acc;
    bit ok;
    for (int i = 0; i < 25; i++) begin
      blank = 1'($urandom_range(0, 1));
      if (!req_ready) blank = 1'b1;
      push(15'($urandom), $urandom, 4'($urandom), 60, acc);
      checks++;
      if (acc < 0) begin errors++; $display("FAIL rand_accept[%0d] got timeout want accept", i); end
      repeat ($urandom_range(0, 2)) begin
        blank = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    blank = 1'b1;
    wait_idle(300, ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d writes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].addr != exp_q[i].addr ||
          obs_q[i].data !== exp_q[i].data || !obs_q[i].blank_ok) begin
        errors++;
        $display("FAIL rand[%0d] got k%0d a%0d d%h blank%0d want k%0d a%0d d%h blank1", i,
                 obs_q[i].kind, obs_q[i].addr, obs_q[i].data, obs_q[i].blank_ok,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (multi_we != 0) begin errors++; $display("FAIL one_hot_we got %0d multi-strobe cycles want 0", multi_we); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_sprite();
    test_tile();
    test_map_blank();
    test_back_to_back();
    test_reset_mid_tile();
    test_pal_be0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
